// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: valid/ready initiator for a csr bank with one-hot write strobes and readback mux.
// Optional macro CSR_WSTRB_EN adds req_wstrb byte enables with read-modify-write merge.
module csr_access_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
`ifdef CSR_WSTRB_EN
  input  logic [DATA_W/8-1:0]        req_wstrb,
`endif
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic [NUM_REGS-1:0]        csr_set,
  output logic [DATA_W-1:0]          csr_wdata,
  input  logic [NUM_REGS*DATA_W-1:0] csr_rdata
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  state_e              state_q, state_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
`ifdef CSR_WSTRB_EN
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
`endif
  logic                in_range;
  logic [DATA_W-1:0]   rd_word, wr_word;
  assign in_range  = int'(addr_q) < NUM_REGS;
  assign rd_word   = in_range ? csr_rdata[int'(addr_q)*DATA_W +: DATA_W] : '0;
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  // strobe decoded purely from registers so it cannot glitch and drops with async reset
  assign csr_set   = (state_q == EXEC && wr_q && in_range) ? NUM_REGS'(1) << addr_q : '0;
  assign csr_wdata = (state_q == EXEC && wr_q) ? wr_word : '0;
  always_comb begin
    wr_word = wdata_q;
`ifdef CSR_WSTRB_EN
    for (int b = 0; b < DATA_W/8; b++)
      wr_word[b*8 +: 8] = wstrb_q[b] ? wdata_q[b*8 +: 8] : rd_word[b*8 +: 8];
`endif
  end
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef CSR_WSTRB_EN
    wstrb_d = wstrb_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        wr_d    = req_write;
        addr_d  = req_addr;
        wdata_d = req_wdata;
`ifdef CSR_WSTRB_EN
        wstrb_d = req_wstrb;
`endif
        state_d = EXEC;
      end
      EXEC: begin
        rdata_d = (!wr_q && in_range) ? rd_word : '0;
        err_d   = !in_range;
        state_d = RESP;
      end
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef CSR_WSTRB_EN
      wstrb_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef CSR_WSTRB_EN
      wstrb_q <= wstrb_d;
`endif
    end
  end
endmodule
